multdiv_issue_ctrl: RTL
=======================

// Module: multdiv_issue_ctrl
// PURPOSE
//  Processor-side initiator for the multi-cycle multdiv unit. It accepts a mult/div op
//  from the execute stage and latches its operands and destination. It then issues a
//  one-cycle ctrl_MULT/ctrl_DIV pulse with the operands held stable, and stalls the
//  pipeline until data_resultRDY. Finally it emits a one-cycle writeback; on exception
//  the writeback is redirected to $rstatus.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max BUSY cycles before abort (used only with MD_TIMEOUT_EN)
//  REG_W           5   register-index width
// PORTS
//  clock           in   1      system clock, rising edge
//  reset           in   1      asynchronous, active-high; clears all state
//  op_valid        in   1      execute stage presents a mult/div op this cycle
//  op_is_div       in   1      1 = div, 0 = mult (sampled with op_valid)
//  op_a, op_b      in   32     operands (sampled with op_valid)
//  op_rd           in   REG_W  destination register
//  flush           in   1      kill the in-flight op (branch/jump squash)
//  md_operandA/B   out  32     latched operands to multdiv, held START..DONE
//  md_ctrl_MULT    out  1      one-cycle start pulse, mult
//  md_ctrl_DIV     out  1      one-cycle start pulse, div
//  md_result       in   32     multdiv data_result
//  md_exception    in   1      multdiv data_exception
//  md_resultRDY    in   1      multdiv data_resultRDY
//  stall           out  1      freeze pipeline while op is outstanding
//  wb_valid        out  1      one-cycle writeback strobe
//  wb_rd           out  REG_W  writeback destination
//  wb_data         out  32     writeback value
// BEHAVIOUR
//  - States: IDLE, START, BUSY, DONE. Reset: IDLE; all outputs 0; latches cleared.
//  - accept = op_valid & ~flush & (IDLE | DONE). On accept: latch a, b, rd and is_div;
//    next state START.
//  - START (exactly 1 cycle): md_ctrl_MULT = ~is_div, md_ctrl_DIV = is_div. md_resultRDY
//    is ignored here (it may be stale from the previous op). Next state BUSY.
//  - BUSY: wait for md_resultRDY = 1. Then register md_result and md_exception and go
//    to DONE.
//  - DONE (1 cycle): wb_valid = 1.
//    - No exception: wb_rd = latched rd, wb_data = result.
//    - Exception: wb_rd = 30, wb_data = 4 (mult) or 5 (div).
//    - DONE accepts a new op like IDLE (back-to-back), going to START; otherwise IDLE.
//  - stall = accept | START | BUSY (combinational). stall is 0 in DONE unless a new op
//    is accepted. Minimum op latency: accept -> wb_valid = RDY latency + 2 cycles.
//  - flush in START or BUSY: go to IDLE and drop stall the same cycle. The pending
//    writeback is discarded and a later md_resultRDY is ignored.
//  - flush in DONE: wb_valid is suppressed that cycle.
//  - flush with op_valid: flush wins, no accept.
//  - md_operandA/B change only on accept; start pulses never overlap.
//  - reset mid-op: immediate IDLE, outputs 0, no writeback.
// CONFIGURATION
//  MD_TIMEOUT_EN defined: a counter clears on entering BUSY and counts BUSY cycles.
//    If TIMEOUT_CYCLES elapse with no md_resultRDY, go to DONE with the exception
//    forced: wb_rd = 30, wb_data = 6.
//  MD_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely.
// TESTING
//  1. mult 7*6, RDY after 32 cycles -> one ctrl_MULT pulse in the cycle after accept;
//     stall held; wb_valid 1 cycle; wb_data = 42, wb_rd = op_rd.
//  2. div 100/0, multdiv raises exception -> wb_rd = 30, wb_data = 5, no write to op_rd.
//  3. Back-to-back: new op_valid during DONE -> wb of op1 and START of op2 in consecutive
//     cycles; op2's operands appear on md_operandA/B.
//  4. flush in BUSY cycle 10, then RDY at cycle 32 -> stall drops the same cycle;
//     wb_valid stays 0.
//  5. Stale md_resultRDY = 1 during START -> ignored; completion only on the next BUSY RDY.
//  6. MD_TIMEOUT_EN, TIMEOUT_CYCLES = 8, RDY never asserted -> wb_valid after 8 BUSY
//     cycles, wb_rd = 30, wb_data = 6.

Source files
------------

// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the multi-cycle multdiv unit: latches an op, pulses start,
// stalls until ready, then writes back (or redirects to $rstatus on exception).
// Optional BUSY watchdog enabled by defining MD_TIMEOUT_EN.
module multdiv_issue_ctrl #(
`ifdef MD_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 64,
`endif
    parameter int unsigned REG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             op_valid,
    input  logic             op_is_div,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    input  logic [REG_W-1:0] op_rd,
    input  logic             flush,
    output logic [31:0]      md_operandA,
    output logic [31:0]      md_operandB,
    output logic             md_ctrl_MULT,
    output logic             md_ctrl_DIV,
    input  logic [31:0]      md_result,
    input  logic             md_exception,
    input  logic             md_resultRDY,
    output logic             stall,
    output logic             wb_valid,
    output logic [REG_W-1:0] wb_rd,
    output logic [31:0]      wb_data
);

    localparam int unsigned RSTATUS_RD = 30;
    localparam logic [31:0] EXC_MULT   = 32'd4;
    localparam logic [31:0] EXC_DIV    = 32'd5;
`ifdef MD_TIMEOUT_EN
    localparam logic [31:0] EXC_TMO    = 32'd6;
    localparam int unsigned CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
`endif

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t           state;
    logic             is_div;
    logic [REG_W-1:0] rd_q;
    logic             accept;
`ifdef MD_TIMEOUT_EN
    logic [CNT_W-1:0] busy_cnt;
`endif

    // Handshake terms that must react within the current cycle.
    always_comb begin
        accept   = 1'b0;
        stall    = 1'b0;
        wb_valid = 1'b0;
        accept   = op_valid & ~flush & ((state == IDLE) | (state == DONE));
        stall    = accept | (((state == START) | (state == BUSY)) & ~flush);
        wb_valid = (state == DONE) & ~flush;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            is_div       <= 1'b0;
            rd_q         <= '0;
            md_operandA  <= '0;
            md_operandB  <= '0;
            md_ctrl_MULT <= 1'b0;
            md_ctrl_DIV  <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
`ifdef MD_TIMEOUT_EN
            busy_cnt     <= '0;
`endif
        end else begin
            md_ctrl_MULT <= 1'b0;
            md_ctrl_DIV  <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state        <= START;
                        is_div       <= op_is_div;
                        rd_q         <= op_rd;
                        md_operandA  <= op_a;
                        md_operandB  <= op_b;
                        md_ctrl_MULT <= ~op_is_div;
                        md_ctrl_DIV  <= op_is_div;
                    end else begin
                        state <= IDLE;
                    end
                end
                // Ready here may be left over from the previous op, so it is not looked at.
                START: begin
                    state <= flush ? IDLE : BUSY;
`ifdef MD_TIMEOUT_EN
                    busy_cnt <= '0;
`endif
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else if (md_resultRDY) begin
                        state <= DONE;
                        if (md_exception) begin
                            wb_rd   <= REG_W'(RSTATUS_RD);
                            wb_data <= is_div ? EXC_DIV : EXC_MULT;
                        end else begin
                            wb_rd   <= rd_q;
                            wb_data <= md_result;
                        end
`ifdef MD_TIMEOUT_EN
                    end else if (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        state   <= DONE;
                        wb_rd   <= REG_W'(RSTATUS_RD);
                        wb_data <= EXC_TMO;
                    end else begin
                        busy_cnt <= busy_cnt + CNT_W'(1);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
